// File: rtl/param_fifo.sv
// Parameterised single-clock circular-buffer FIFO with sticky overflow/underflow flags.
// Read mode: define PARAM_FIFO_FWFT_EN for first-word fall-through, otherwise registered read.
module param_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       out_data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push_acc;
  logic pop_acc;

  // Status flags are pure decodes of the registered occupancy.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);

  // A full FIFO can still take a push when a pop frees the slot on the same edge;
  // an empty FIFO never honours a pop, even alongside a push.
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q && !clr_err;
    underflow_d = underflow_q && !clr_err;

    if (push_acc) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop_acc) begin
      head_d = head_q + PTR_W'(1);
    end

    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh error wins over a simultaneous clear.
    if (push && !push_acc) begin
      overflow_d = 1'b1;
    end
    if (pop && !pop_acc) begin
      underflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[tail_q] <= in_data;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign out_data = mem_q[head_q];
`else
  logic [WIDTH-1:0] out_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q <= '0;
    end else if (pop_acc) begin
      out_data_q <= mem_q[head_q];
    end
  end

  assign out_data = out_data_q;
`endif

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, 32, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, 4, number of entries (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, DEPTH-1, count at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, 1, count at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port in_data  input  WIDTH  write data.
REQ-008 The block SHALL have port push  input  1  write request.
REQ-009 The block SHALL have port pop  input  1  read request.
REQ-010 The block SHALL have port clr_err  input  1  synchronous clear of the sticky error flags.
REQ-011 The block SHALL have port out_data  output  WIDTH  read data.
REQ-012 The block SHALL have port full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 The block SHALL have port almost_full / almost_empty  output  1 each  count>=AF_LEVEL / count<=AE_LEVEL.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 The block SHALL have port overflow / underflow  output  1 each  sticky rejected-push / rejected-pop flags.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH circular buffer with head (read) and tail (write) pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-017 An accepted push SHALL write in_data at tail, advance tail by 1 and increment count, all in the same edge.
REQ-018 An accepted pop SHALL advance head by 1 and decrement count.
REQ-019 push SHALL be accepted when !full, or when full and pop is asserted in the same cycle.
REQ-020 pop SHALL be accepted only when !empty; pop with empty SHALL be ignored even if push is asserted that cycle.
REQ-021 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 A rejected push SHALL leave memory, pointers and count unchanged and set overflow on the next edge.
REQ-023 A rejected pop SHALL leave out_data, pointers and count unchanged and set underflow on the next edge.
REQ-024 overflow/underflow SHALL hold until clr_err or reset; clr_err together with a new error SHALL leave the flag set.
REQ-025 full, empty, almost_full, almost_empty SHALL be combinational decodes of the registered count.
REQ-026 Data SHALL leave in strict push order; no entry is ever duplicated or skipped across pointer wrap.

Reset
REQ-027 rst low SHALL asynchronously clear head, tail, count, overflow, underflow and out_data to 0, regardless of clk.
REQ-028 After reset: empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL>=1); memory contents need not be cleared.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; the first push after release is the first word read.
REQ-030 push/pop SHALL be ignored while rst is low; the first edge after release SHALL be fully functional.

Configuration
REQ-031 Macro PARAM_FIFO_FWFT_EN SHALL select the read mode.
REQ-032 With PARAM_FIFO_FWFT_EN defined: out_data SHALL combinationally equal mem[head] while !empty (first-word fall-through, zero pop latency); pop consumes the word shown; out_data is don't-care while empty.
REQ-033 Without PARAM_FIFO_FWFT_EN: out_data SHALL be a register loaded with mem[head] on the edge that accepts a pop (1-cycle latency) and SHALL hold its value otherwise.

Verification
REQ-034 Reset, push 0x11,0x22,0x33,0x44 (DEPTH=4) -> count 1..4, almost_full at count 3, full at 4, overflow=0.
REQ-035 Fifth push 0x55 while full, no pop -> overflow=1, count=4; then 4 pops -> 0x11,0x22,0x33,0x44 in order, empty=1.
REQ-036 Pop while empty -> underflow=1, count=0, out_data unchanged; clr_err one cycle -> underflow=0.
REQ-037 16 cycles of simultaneous push/pop of random data starting at count=2 -> count stays 2, output sequence equals input delayed by 2 entries across pointer wrap.
REQ-038 Full FIFO with push 0x66 + pop same cycle -> 0x11 read, count stays 4, overflow=0; empty FIFO with push+pop -> count=1, underflow=1.
REQ-039 Assert rst low between clock edges with count=3 -> count=0, empty=1 immediately; run REQ-034..038 with and without PARAM_FIFO_FWFT_EN and WIDTH=8, DEPTH=16.
